// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock, op_start/op_clear/op_done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (magnitude core plus sign fix-up on output load).
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op_start,
  input  logic             op_clear,
  output logic             op_done,
  output logic [WIDTH-1:0] DIV_quotient,
  output logic [WIDTH-1:0] DIV_remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, DONE = 2'b10} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, q_out_q, r_out_q;
  logic             done_q, dbz_q, zero_q;
  logic [WIDTH:0]   shift_d;
  logic [WIDTH-1:0] trial_d, rem_d, quo_d, dvd_mag, dvs_mag, q_fix, r_fix;
  logic             ge;
  assign shift_d = {rem_q, quo_q[WIDTH-1]};
  assign ge      = shift_d >= {1'b0, dvs_q};
  assign trial_d = shift_d[WIDTH-1:0] - dvs_q;
  assign rem_d   = ge ? trial_d : shift_d[WIDTH-1:0];
  assign quo_d   = {quo_q[WIDTH-2:0], ge};
`ifdef SIGNED_DIV_EN
  logic neg_q_q, neg_r_q;
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
  // divide-by-zero forces -1 regardless of the dividend sign
  assign q_fix   = zero_q ? '1 : neg_q_q ? -quo_d : quo_d;
  assign r_fix   = neg_r_q ? -rem_d : rem_d;
  always_ff @(posedge clk) begin
    if (!reset_n || op_clear) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (state_q == IDLE && op_start) begin
      neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_q <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = quo_d;
  assign r_fix   = rem_d;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n || op_clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (op_start) begin
          state_q <= EXEC;
          cnt_q   <= '0;
          rem_q   <= '0;
          quo_q   <= dvd_mag;
          dvs_q   <= dvs_mag;
          zero_q  <= divisor == '0;
        end
        EXEC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            dbz_q   <= zero_q;
            q_out_q <= q_fix;
            r_out_q <= r_fix;
          end
        end
        DONE: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign op_done       = done_q;
  assign DIV_quotient  = q_out_q;
  assign DIV_remainder = r_out_q;
  assign div_by_zero   = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random divisions checked against plain-arithmetic reference results.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        op_start = 1'b0;
  logic        op_clear = 1'b0;
  logic        op_done;
  logic [31:0] DIV_quotient, DIV_remainder;
  logic        div_by_zero;
  int          checks = 0;
  int          errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .dividend(dividend), .divisor(divisor),
    .op_start(op_start), .op_clear(op_clear), .op_done(op_done),
    .DIV_quotient(DIV_quotient), .DIV_remainder(DIV_remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    z = (b == 0);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end
`ifdef SIGNED_DIV_EN
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
`else
    else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".done"}, 32'(op_done), 0);
    chk({tag, ".q"}, DIV_quotient, 0);
    chk({tag, ".r"}, DIV_remainder, 0);
    chk({tag, ".dbz"}, 32'(div_by_zero), 0);
  endtask

  // Start at the next edge, count edges (start edge = 1) until op_done, check results, then clear.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] eq, er;
    logic ez;
    int n;
    ref_div(a, b, eq, er, ez);
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (!hold) op_start = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
    end while (!op_done && n < 60);
    chk({tag, ".latency"}, 32'(n), 33);
    chk({tag, ".q"}, DIV_quotient, eq);
    chk({tag, ".r"}, DIV_remainder, er);
    chk({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
    if (hold) begin
      repeat (5) tick();
      chk({tag, ".hold_done"}, 32'(op_done), 1);
      chk({tag, ".hold_q"}, DIV_quotient, eq);
      chk({tag, ".hold_r"}, DIV_remainder, er);
    end
    op_start = 1'b0;
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    check_idle({tag, ".clear"});
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    bit seen = 0;
    repeat (cycles) begin
      tick();
      if (op_done) seen = 1;
    end
    chk(tag, 32'(seen), 0);
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (2) tick();
    check_idle("reset");
    reset_n = 1'b1;
    tick();
    check_idle("post_reset");
    run_op("t1_100_7", 100, 7, 0);
    run_op("t2_div0", 32'h1234_5678, 0, 0);
    run_op("t3_full_hold", 32'hFFFF_FFFF, 1, 1);
    // op_clear sampled at the EXEC step with counter=10
    dividend = 1234;
    divisor  = 7;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (10) tick();
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    check_idle("t4_abort");
    watch_no_done("t4_no_done", 40);
    run_op("t4_50_5", 50, 5, 0);
    // reset sampled at the EXEC step with counter=20
    dividend = 1000;
    divisor  = 3;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (20) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_idle("t5_reset");
    watch_no_done("t5_no_done", 40);
    run_op("t5_81_9", 81, 9, 0);
    // op_start together with op_clear in IDLE must not start anything
    dividend = 77;
    divisor  = 7;
    op_start = 1'b1;
    op_clear = 1'b1;
    tick();
    op_start = 1'b0;
    op_clear = 1'b0;
    watch_no_done("start_and_clear", 40);
    run_op("neg7_2", 32'hFFFF_FFF9, 2, 0);
    run_op("minneg_m1", 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("small_big", 5, 32'hFFFF_FFF0, 0);
    run_op("equal", 32'h8765_4321, 32'h8765_4321, 0);
    run_op("zero_dvd", 0, 13, 0);
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), a, b, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
